// File: rtl/tone_arbiter_pkg.sv
// Shared audio definitions: arbiter states, source codes, sample scaling.
package tone_arbiter_pkg;

  localparam int unsigned VOL_W    = 3;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned SRC_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_MUS          = 2'd1,
    ST_SFX          = 2'd2,
    ST_SFX_OVER_MUS = 2'd3
  } state_e;

  localparam logic [SRC_W-1:0] SRC_NONE = 2'b00;
  localparam logic [SRC_W-1:0] SRC_MUS  = 2'b01;
  localparam logic [SRC_W-1:0] SRC_SFX  = 2'b10;

  localparam logic [SAMPLE_W-1:0] AMP_STEP = 16'h0800;

  // Source code reported for a given arbiter state.
  function automatic logic [SRC_W-1:0] src_of(input state_e s);
    case (s)
      ST_MUS:                  return SRC_MUS;
      ST_SFX, ST_SFX_OVER_MUS: return SRC_SFX;
      default:                 return SRC_NONE;
    endcase
  endfunction

  // Square-wave amplitude for a volume step.
  function automatic logic [SAMPLE_W-1:0] amp_of(input logic [VOL_W-1:0] vol);
    return SAMPLE_W'(vol) * AMP_STEP;
  endfunction

endpackage

// File: rtl/tone_arbiter_if.sv
// One tone requester: note fields with a req/ack handshake and done pulse.
interface tone_arbiter_if #(
  parameter int unsigned HP_W  = 22,
  parameter int unsigned DUR_W = 16
);
  import tone_arbiter_pkg::*;

  logic             req;
  logic [HP_W-1:0]  hp;
  logic [DUR_W-1:0] dur;
  logic [VOL_W-1:0] vol;
  logic             ack;
  logic             done;

  modport master (output req, hp, dur, vol, input ack, done);
  modport slave  (input req, hp, dur, vol, output ack, done);
endinterface

// File: rtl/tone_arbiter_tone_gen.sv
// Tone engine: duration prescaler, remaining-tick count, half-period counter and phase.
module tone_gen #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned HP_W     = 22,
  parameter int unsigned DUR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [HP_W-1:0]  ld_hp,
  input  logic [DUR_W-1:0] ld_dur,
  input  logic             restore,
  input  logic [HP_W-1:0]  rs_hp,
  input  logic [DUR_W-1:0] rs_dur,
  input  logic             rs_phase,
  input  logic             run,
  output logic [HP_W-1:0]  hp,
  output logic             phase,
  output logic             expire_c,
  output logic [DUR_W-1:0] save_rem_c
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [HP_W-1:0]  cnt_q, cnt_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             phase_q, phase_d;
  logic             tick_c;

  assign tick_c     = (presc_q == PRE_MAX);
  // A zero-length note ends on its first running cycle.
  assign expire_c   = run && ((rem_q == '0) || (tick_c && (rem_q == DUR_W'(1))));
  // Remaining ticks as they will stand after this edge; partial tick is dropped.
  assign save_rem_c = tick_c ? (rem_q - DUR_W'(1)) : rem_q;
  assign hp         = hp_q;
  assign phase      = phase_q;

  // Next-state for the counters: load, restore, or advance while running.
  always_comb begin
    presc_d = presc_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    if (load) begin
      hp_d    = ld_hp;
      rem_d   = ld_dur;
      presc_d = '0;
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (restore) begin
      hp_d    = rs_hp;
      rem_d   = rs_dur;
      presc_d = '0;
      cnt_d   = '0;
      phase_d = rs_phase;
    end else if (run) begin
      if (tick_c) begin
        presc_d = '0;
        if (rem_q != '0) rem_d = rem_q - DUR_W'(1);
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
      if (hp_q != '0) begin
        if (cnt_q == (hp_q - HP_W'(1))) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + HP_W'(1);
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      hp_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      presc_q <= presc_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/tone_arbiter.sv
// Two-source tone arbiter: sound effects preempt music, which resumes afterwards.
module tone_arbiter
  import tone_arbiter_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned HP_W     = 22,
  parameter int unsigned DUR_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  tone_arbiter_if.slave       mus,
  tone_arbiter_if.slave       sfx,
  input  logic                mute,
  output logic [SAMPLE_W-1:0] audio_left,
  output logic [SAMPLE_W-1:0] audio_right,
  output logic [SRC_W-1:0]    active_src,
  output logic                mus_paused
);

  typedef struct packed {
    logic [HP_W-1:0]  hp;
    logic [DUR_W-1:0] rem;
    logic [VOL_W-1:0] vol;
    logic             phase;
  } ctx_t;

  state_e              state_q, state_d;
  ctx_t                ctx_q, ctx_d;
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic                mus_ack_q, mus_ack_d, mus_done_q, mus_done_d;
  logic                sfx_ack_q, sfx_ack_d, sfx_done_q, sfx_done_d;
  logic                mus_blk_q, mus_blk_d, sfx_blk_q, sfx_blk_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic                paused_q, paused_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;

  logic                load_c, restore_c, run_c;
  logic [HP_W-1:0]     ld_hp_c;
  logic [DUR_W-1:0]    ld_dur_c;
  logic                acc_mus_c, acc_sfx_c, fin_mus_c, fin_sfx_c, leave_sfx_c;
  logic                mus_ok_c, sfx_ok_c;
  logic [HP_W-1:0]     tone_hp;
  logic                tone_phase, expire_c;
  logic [DUR_W-1:0]    save_rem_c;
  logic [SAMPLE_W-1:0] amp_c;

  // A requester is eligible once its req has dropped or its note has finished.
  assign mus_ok_c = mus.req && !mus_blk_q;
  assign sfx_ok_c = sfx.req && !sfx_blk_q;

  assign mus.ack     = mus_ack_q;
  assign mus.done    = mus_done_q;
  assign sfx.ack     = sfx_ack_q;
  assign sfx.done    = sfx_done_q;
  assign audio_left  = sample_q;
  assign audio_right = sample_q;
  assign active_src  = src_q;
  assign mus_paused  = paused_q;

  tone_gen #(
    .TICK_DIV (TICK_DIV),
    .HP_W     (HP_W),
    .DUR_W    (DUR_W)
  ) u_tone_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_c),
    .ld_hp      (ld_hp_c),
    .ld_dur     (ld_dur_c),
    .restore    (restore_c),
    .rs_hp      (ctx_q.hp),
    .rs_dur     (ctx_q.rem),
    .rs_phase   (ctx_q.phase),
    .run        (run_c),
    .hp         (tone_hp),
    .phase      (tone_phase),
    .expire_c   (expire_c),
    .save_rem_c (save_rem_c)
  );

  // Arbitration FSM: acceptance, preemption, expiry and music resume.
  always_comb begin
    state_d     = state_q;
    ctx_d       = ctx_q;
    vol_d       = vol_q;
    mus_ack_d   = 1'b0;
    mus_done_d  = 1'b0;
    sfx_ack_d   = 1'b0;
    sfx_done_d  = 1'b0;
    mus_blk_d   = mus_blk_q && mus.req;
    sfx_blk_d   = sfx_blk_q && sfx.req;
    load_c      = 1'b0;
    restore_c   = 1'b0;
    run_c       = 1'b0;
    ld_hp_c     = mus.hp;
    ld_dur_c    = mus.dur;
    acc_mus_c   = 1'b0;
    acc_sfx_c   = 1'b0;
    fin_mus_c   = 1'b0;
    fin_sfx_c   = 1'b0;
    leave_sfx_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sfx_ok_c) begin
          acc_sfx_c = 1'b1;
          state_d   = ST_SFX;
        end else if (mus_ok_c) begin
          acc_mus_c = 1'b1;
          state_d   = ST_MUS;
        end
      end
      ST_MUS: begin
        run_c = 1'b1;
        if (expire_c) begin
          fin_mus_c = 1'b1;
          state_d   = ST_IDLE;
        end else if (sfx_ok_c) begin
          ctx_d.hp    = tone_hp;
          ctx_d.rem   = save_rem_c;
          ctx_d.vol   = vol_q;
          ctx_d.phase = tone_phase;
          acc_sfx_c   = 1'b1;
          state_d     = ST_SFX_OVER_MUS;
        end
      end
      ST_SFX, ST_SFX_OVER_MUS: begin
        if (sfx_done_q) begin
          // Held one cycle after sfx_done so a waiting sfx is taken without an ack/done overlap.
          if (sfx_ok_c) acc_sfx_c   = 1'b1;
          else          leave_sfx_c = 1'b1;
        end else begin
          run_c = 1'b1;
          if (expire_c) begin
            fin_sfx_c = 1'b1;
            if (!sfx.req) leave_sfx_c = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (leave_sfx_c) begin
      if (state_q == ST_SFX_OVER_MUS) begin
        restore_c = 1'b1;
        vol_d     = ctx_q.vol;
        state_d   = ST_MUS;
      end else begin
        state_d = ST_IDLE;
      end
    end
    if (acc_sfx_c) begin
      sfx_ack_d = 1'b1;
      sfx_blk_d = 1'b1;
      load_c    = 1'b1;
      ld_hp_c   = sfx.hp;
      ld_dur_c  = sfx.dur;
      vol_d     = sfx.vol;
    end
    if (acc_mus_c) begin
      mus_ack_d = 1'b1;
      mus_blk_d = 1'b1;
      load_c    = 1'b1;
      vol_d     = mus.vol;
    end
    if (fin_mus_c) begin
      mus_done_d = 1'b1;
      mus_blk_d  = 1'b0;
    end
    if (fin_sfx_c) begin
      sfx_done_d = 1'b1;
      sfx_blk_d  = 1'b0;
    end

    src_d    = src_of(state_d);
    paused_d = (state_d == ST_SFX_OVER_MUS);
  end

  // Output sample from the current state and phase; silent when idle, muted, or hp/vol is zero.
  always_comb begin
    amp_c    = amp_of(vol_q);
    sample_d = '0;
    if ((state_q != ST_IDLE) && !mute && (vol_q != '0) && (tone_hp != '0)) begin
      sample_d = tone_phase ? amp_c : (~amp_c + SAMPLE_W'(1));
    end
  end

  // State, context and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ctx_q      <= '0;
      vol_q      <= '0;
      mus_ack_q  <= 1'b0;
      mus_done_q <= 1'b0;
      sfx_ack_q  <= 1'b0;
      sfx_done_q <= 1'b0;
      mus_blk_q  <= 1'b0;
      sfx_blk_q  <= 1'b0;
      src_q      <= SRC_NONE;
      paused_q   <= 1'b0;
      sample_q   <= '0;
    end else begin
      state_q    <= state_d;
      ctx_q      <= ctx_d;
      vol_q      <= vol_d;
      mus_ack_q  <= mus_ack_d;
      mus_done_q <= mus_done_d;
      sfx_ack_q  <= sfx_ack_d;
      sfx_done_q <= sfx_done_d;
      mus_blk_q  <= mus_blk_d;
      sfx_blk_q  <= sfx_blk_d;
      src_q      <= src_d;
      paused_q   <= paused_d;
      sample_q   <= sample_d;
    end
  end

endmodule

// File: tb/tb_tone_arbiter.sv
// Self-checking bench for tone_arbiter with TICK_DIV=10 and a cycle-count reference model.
module tb_tone_arbiter;

  localparam int TD    = 10;
  localparam int HP_W  = 22;
  localparam int DUR_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mute;
  logic [15:0] audio_left, audio_right;
  logic [1:0]  active_src;
  logic        mus_paused;

  int errors = 0;
  int checks = 0;

  tone_arbiter_if #(.HP_W(HP_W), .DUR_W(DUR_W)) mus_if ();
  tone_arbiter_if #(.HP_W(HP_W), .DUR_W(DUR_W)) sfx_if ();

  tone_arbiter #(.TICK_DIV(TD), .HP_W(HP_W), .DUR_W(DUR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mus         (mus_if),
    .sfx         (sfx_if),
    .mute        (mute),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .active_src  (active_src),
    .mus_paused  (mus_paused)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Square wave of a note j cycles after its acceptance: high for hp cycles, low for hp cycles.
  function automatic logic [15:0] exp_sample(input int hp, input int vol, input int j, input bit m);
    int amp;
    if (m || vol == 0 || hp == 0) return 16'h0000;
    amp = vol * 2048;
    if (((j / hp) % 2) == 0) return 16'(amp);
    return 16'(65536 - amp);
  endfunction

  function automatic int note_len(input int dur);
    return (dur == 0) ? 1 : dur * TD;
  endfunction

  task automatic set_mus(input bit r, input int hp, input int dur, input int vol);
    mus_if.req = r; mus_if.hp = HP_W'(hp); mus_if.dur = DUR_W'(dur); mus_if.vol = 3'(vol);
  endtask

  task automatic set_sfx(input bit r, input int hp, input int dur, input int vol);
    sfx_if.req = r; sfx_if.hp = HP_W'(hp); sfx_if.dur = DUR_W'(dur); sfx_if.vol = 3'(vol);
  endtask

  task automatic test_reset();
    logic [39:0] got;
    rst_n = 1'b0; mute = 1'b0;
    set_mus(0, 0, 0, 0); set_sfx(0, 0, 0, 0);
    step(); step();
    got = {audio_left, audio_right, active_src, mus_paused, mus_if.ack, mus_if.done, sfx_if.ack, sfx_if.done};
    checks++;
    if (got !== 40'h0) begin errors++; $display("FAIL reset_hold: outputs=%h want 0", got); end
    rst_n = 1'b1;
    step(); step();
    got = {audio_left, audio_right, active_src, mus_paused, mus_if.ack, mus_if.done, sfx_if.ack, sfx_if.done};
    checks++;
    if (got !== 40'h0) begin errors++; $display("FAIL reset_release: outputs=%h want 0", got); end
  endtask

  // One music note from IDLE, checked cycle by cycle against the waveform model.
  task automatic run_note(input int hp, input int dur, input int vol, input bit rmute, input string tag);
    int d, bad_a, bad_d, bad_s, first_k;
    bit mprev;
    logic [15:0] exp_a, got_a, want_a;
    d = note_len(dur);
    bad_a = 0; bad_d = 0; bad_s = 0; first_k = -1; got_a = '0; want_a = '0;
    set_mus(1, hp, dur, vol);
    step();
    checks++;
    if (mus_if.ack !== 1'b1 || sfx_if.ack !== 1'b0 || active_src !== 2'b01) begin
      errors++;
      $display("FAIL %s_ack: mus_ack=%b sfx_ack=%b src=%b want 1 0 01", tag, mus_if.ack, sfx_if.ack, active_src);
    end
    mus_if.req = 1'b0;
    for (int k = 1; k <= d + 1; k++) begin
      mute = rmute ? ($urandom_range(0, 2) == 0) : 1'b0;
      mprev = mute;
      step();
      exp_a = (k <= d) ? exp_sample(hp, vol, k - 1, mprev) : 16'h0000;
      if (audio_left !== exp_a || audio_right !== exp_a) begin
        if (bad_a == 0) begin first_k = k; got_a = audio_left; want_a = exp_a; end
        bad_a++;
      end
      if (mus_if.done !== 1'(k == d) || mus_if.ack !== 1'b0) bad_d++;
      if (active_src !== ((k < d) ? 2'b01 : 2'b00)) bad_s++;
    end
    mute = 1'b0;
    checks++;
    if (bad_a != 0) begin
      errors++;
      $display("FAIL %s_audio: %0d bad cycles, first at %0d got %h want %h", tag, bad_a, first_k, got_a, want_a);
    end
    checks++;
    if (bad_d != 0) begin errors++; $display("FAIL %s_done: %0d cycles wrong, want done only at %0d", tag, bad_d, d); end
    checks++;
    if (bad_s != 0) begin errors++; $display("FAIL %s_src: %0d cycles with wrong active_src", tag, bad_s); end
  endtask

  task automatic test_basic();
    run_note(3, 2, 1, 1'b0, "basic");
  endtask

  task automatic test_silent_hp0();
    run_note(0, 1, 7, 1'b0, "hp0");
  endtask

  task automatic test_mute();
    run_note(4, 3, 5, 1'b1, "mute");
  endtask

  task automatic test_random_notes();
    for (int i = 0; i < 6; i++) begin
      run_note(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), "rand");
    end
  endtask

  task automatic test_priority();
    int hm, vm, dm, hs, vs, ds, len_s, len_m;
    logic [63:0] sdone_v, mack_v, mdone_v, e1, e2;
    hm = $urandom_range(1, 7); vm = $urandom_range(1, 7); dm = $urandom_range(1, 2);
    hs = $urandom_range(1, 7); vs = $urandom_range(1, 7); ds = $urandom_range(0, 2);
    len_s = note_len(ds); len_m = note_len(dm);
    set_mus(1, hm, dm, vm); set_sfx(1, hs, ds, vs);
    step();
    checks++;
    if (sfx_if.ack !== 1'b1 || mus_if.ack !== 1'b0 || active_src !== 2'b10) begin
      errors++;
      $display("FAIL prio_ack: sfx_ack=%b mus_ack=%b src=%b want 1 0 10", sfx_if.ack, mus_if.ack, active_src);
    end
    sfx_if.req = 1'b0;
    sdone_v = '0; mack_v = '0;
    for (int k = 1; k <= len_s + 1; k++) begin
      step();
      sdone_v[k] = sfx_if.done;
      mack_v[k]  = mus_if.ack;
    end
    mus_if.req = 1'b0;
    e1 = '0; e1[len_s] = 1'b1;
    e2 = '0; e2[len_s + 1] = 1'b1;
    checks++;
    if (sdone_v !== e1 || mack_v !== e2) begin
      errors++;
      $display("FAIL prio_seq: sfx_done=%h mus_ack=%h want %h %h", sdone_v, mack_v, e1, e2);
    end
    checks++;
    if (active_src !== 2'b01) begin errors++; $display("FAIL prio_src: src=%b want 01", active_src); end
    mdone_v = '0;
    for (int j = 1; j <= len_m + 1; j++) begin
      step();
      mdone_v[j] = mus_if.done;
    end
    e1 = '0; e1[len_m] = 1'b1;
    checks++;
    if (mdone_v !== e1) begin errors++; $display("FAIL prio_mus_done: got %h want %h", mdone_v, e1); end
  endtask

  // Music dur=5 preempted two ticks in by a one-tick sfx, then resumed with three ticks left.
  task automatic test_preempt();
    int hm, vm, hs, vs;
    logic [63:0] mdone_v, sdone_v, e1, e2;
    logic p29, p30;
    logic [15:0] a22, a31;
    hm = $urandom_range(1, 7); vm = $urandom_range(1, 7);
    hs = $urandom_range(1, 7); vs = $urandom_range(1, 7);
    mdone_v = '0; sdone_v = '0; p29 = 1'b0; p30 = 1'b1; a22 = '0; a31 = '0;
    set_mus(1, hm, 5, vm);
    step();
    mus_if.req = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      step();
      mdone_v[k] = mus_if.done;
    end
    set_sfx(1, hs, 1, vs);
    step();
    checks++;
    if (sfx_if.ack !== 1'b1 || mus_paused !== 1'b1 || active_src !== 2'b10 || mus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL preempt_ack: sfx_ack=%b paused=%b src=%b mus_done=%b want 1 1 10 0",
               sfx_if.ack, mus_paused, active_src, mus_if.done);
    end
    sfx_if.req = 1'b0;
    for (int k = 21; k <= 62; k++) begin
      step();
      mdone_v[k] = mus_if.done;
      sdone_v[k] = sfx_if.done;
      if (k == 22) a22 = audio_left;
      if (k == 29) p29 = mus_paused;
      if (k == 30) p30 = mus_paused;
      if (k == 31) a31 = audio_left;
    end
    e1 = '0; e1[60] = 1'b1;
    e2 = '0; e2[30] = 1'b1;
    checks++;
    if (mdone_v !== e1) begin errors++; $display("FAIL preempt_mus_done: got %h want %h", mdone_v, e1); end
    checks++;
    if (sdone_v !== e2) begin errors++; $display("FAIL preempt_sfx_done: got %h want %h", sdone_v, e2); end
    checks++;
    if (p29 !== 1'b1 || p30 !== 1'b0) begin
      errors++; $display("FAIL preempt_paused: at29=%b at30=%b want 1 0", p29, p30);
    end
    checks++;
    if (a22 !== exp_sample(hs, vs, 1, 1'b0)) begin
      errors++; $display("FAIL preempt_sfx_audio: got %h want %h", a22, exp_sample(hs, vs, 1, 1'b0));
    end
    checks++;
    if (a31 !== exp_sample(hm, vm, 19, 1'b0)) begin
      errors++; $display("FAIL resume_audio: got %h want %h", a31, exp_sample(hm, vm, 19, 1'b0));
    end
  endtask

  // A held sfx_req is re-accepted the cycle after sfx_done, never together with it.
  task automatic test_back_to_back();
    logic [31:0] ack_v, done_v, e_ack, e_done;
    logic src10;
    ack_v = '0; done_v = '0; src10 = 1'b0;
    set_sfx(1, int'($urandom_range(1, 7)), 1, int'($urandom_range(0, 7)));
    step();
    ack_v[0] = sfx_if.ack;
    for (int k = 1; k <= 23; k++) begin
      step();
      ack_v[k]  = sfx_if.ack;
      done_v[k] = sfx_if.done;
      if (k == 10) src10 = (active_src == 2'b10);
      if (k == 11) sfx_if.req = 1'b0;
    end
    e_ack = 32'h0000_0801;
    e_done = 32'h0020_0400;
    checks++;
    if (ack_v !== e_ack || done_v !== e_done) begin
      errors++;
      $display("FAIL b2b_seq: ack=%h done=%h want %h %h", ack_v, done_v, e_ack, e_done);
    end
    checks++;
    if (src10 !== 1'b1) begin errors++; $display("FAIL b2b_src: src at done not 10"); end
  endtask

  // Reset while sfx plays over paused music discards both notes silently.
  task automatic test_reset_mid();
    logic [35:0] got;
    int bad;
    logic [15:0] done_v, e;
    set_mus(1, int'($urandom_range(1, 7)), 5, int'($urandom_range(1, 7)));
    step();
    mus_if.req = 1'b0;
    for (int k = 1; k <= 19; k++) step();
    set_sfx(1, int'($urandom_range(1, 7)), 5, int'($urandom_range(1, 7)));
    step();
    sfx_if.req = 1'b0;
    checks++;
    if (mus_paused !== 1'b1) begin errors++; $display("FAIL rstmid_paused: got %b want 1", mus_paused); end
    for (int k = 21; k <= 25; k++) step();
    rst_n = 1'b0;
    #1;
    got = {audio_left, audio_right, active_src, mus_paused, mus_if.done, sfx_if.done};
    checks++;
    if (got !== 36'h0) begin errors++; $display("FAIL rstmid_outputs: got %h want 0", got); end
    step(); step();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (mus_if.done !== 1'b0 || sfx_if.done !== 1'b0 || mus_if.ack !== 1'b0 || sfx_if.ack !== 1'b0 ||
          active_src !== 2'b00 || audio_left !== 16'h0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: %0d cycles with activity", bad); end
    set_mus(1, 2, 1, 3);
    step();
    checks++;
    if (mus_if.ack !== 1'b1 || active_src !== 2'b01) begin
      errors++; $display("FAIL rstmid_new_ack: ack=%b src=%b want 1 01", mus_if.ack, active_src);
    end
    mus_if.req = 1'b0;
    done_v = '0;
    for (int k = 1; k <= 12; k++) begin
      step();
      done_v[k] = mus_if.done;
    end
    e = '0; e[10] = 1'b1;
    checks++;
    if (done_v !== e) begin errors++; $display("FAIL rstmid_new_done: got %h want %h", done_v, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_silent_hp0();
    test_mute();
    test_random_notes();
    test_priority();
    test_preempt();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_arbiter.md
TONE_ARBITER -- requirements
Module: tone_arbiter

Interface
REQ-001 Parameter TICK_DIV, default 100000, SHALL set clk cycles per duration tick (1 ms at 100 MHz).
REQ-002 Parameter HP_W, default 22, SHALL set the width of the half-period field.
REQ-003 Parameter DUR_W, default 16, SHALL set the width of the duration field, in ticks.
REQ-004 clk  in  1  system clock, the crystal clock shared with the I2S speaker controller.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 mus_req  in  1  music requester has a note pending, level held until mus_ack.
REQ-007 mus_hp  in  HP_W  music half-period in clk cycles; 0 = rest (silence).
REQ-008 mus_dur  in  DUR_W  music note duration in ticks.
REQ-009 mus_vol  in  3  music volume, 0..7.
REQ-010 mus_ack  out  1  one-cycle pulse: music note accepted and fields captured.
REQ-011 mus_done  out  1  one-cycle pulse: music note finished.
REQ-012 sfx_req, sfx_hp, sfx_dur, sfx_vol, sfx_ack, sfx_done  SHALL be identical in direction and width to the mus_* signals, serving the sound-effect requester.
REQ-013 mute  in  1  forces both sample outputs to zero; timing is unaffected.
REQ-014 audio_left  out  16  signed sample to the speaker controller's left input.
REQ-015 audio_right  out  16  signed sample to the speaker controller's right input.
REQ-016 active_src  out  2  source playing: 00 none, 01 music, 10 sfx.
REQ-017 mus_paused  out  1  a preempted music note is held for resume.

Function
REQ-018 FSM states SHALL be IDLE, MUS, SFX and SFX_OVER_MUS.
REQ-019 Priority: sfx over music. In IDLE with both req high, sfx SHALL be accepted.
REQ-020 Acceptance: on the cycle ack pulses, hp/dur/vol SHALL be captured, tick prescaler and half-period counter cleared, phase set to 1.
REQ-021 A requester SHALL not be re-acked until its req is sampled low or its done has pulsed.
REQ-022 IDLE->MUS on mus_req; IDLE->SFX on sfx_req.
REQ-023 MUS->SFX_OVER_MUS on sfx_req: current music hp, vol, remaining duration and phase SHALL be saved; mus_paused=1; no mus_done.
REQ-024 MUS->IDLE when duration expires, with a mus_done pulse.
REQ-025 SFX->IDLE on expiry, with an sfx_done pulse.
REQ-026 SFX_OVER_MUS->MUS on sfx expiry: sfx_done pulses; the saved music note resumes from its saved remaining duration and phase; mus_paused=0.
REQ-027 A second sfx_req during SFX or SFX_OVER_MUS SHALL wait; it is accepted on the cycle after sfx_done, and the state stays SFX/SFX_OVER_MUS.
REQ-028 Duration: the prescaler counts 0..TICK_DIV-1; at wrap the remaining duration decrements. Expiry is the wrap at which remaining==1.
REQ-029 dur==0 SHALL expire on the cycle after ack.
REQ-030 Tone: the half-period counter counts 0..hp-1 and toggles phase at wrap.
REQ-031 hp==0 SHALL hold phase and output zero.
REQ-032 Amplitude SHALL be vol*16'h0800. The sample is +amp when phase=1 and -amp (two's complement) when phase=0.
REQ-033 vol==0, mute, or IDLE SHALL output 16'h0000.
REQ-034 audio_left and audio_right SHALL be registered, equal, and updated one cycle after the phase/state change.
REQ-035 A done pulse and the next ack SHALL never share a cycle.

Reset
REQ-036 rst_n low SHALL asynchronously force: state IDLE, all counters and saved context 0, phase 1, and outputs audio_left/right=0, active_src=00, mus_ack=mus_done=sfx_ack=sfx_done=0, mus_paused=0.
REQ-037 Reset mid-note SHALL discard the note with no done pulse.

Structure
REQ-038 State encoding, source codes (00/01/10) and the amplitude step 16'h0800 SHALL live in the shared audio package.
REQ-039 One sub-module, tone_gen, SHALL hold the prescaler, half-period counter, phase and load/save/restore ports, instantiated once; the saved context is held in tone_arbiter.

Verification (TICK_DIV=10)
REQ-040 IDLE, mus_req hp=3 dur=2 vol=1 -> mus_ack next edge; samples alternate +0x0800/-0x0800 every 3 cycles; mus_done exactly 20 cycles after ack.
REQ-041 mus_req and sfx_req high together in IDLE -> sfx_ack only, active_src=10; music acked the cycle after sfx_done.
REQ-042 Music dur=5, sfx_req at tick 2 with dur=1 -> mus_paused=1, no mus_done; after sfx_done music resumes with 3 ticks remaining; mus_done 50 cycles after mus_ack plus 10 sfx cycles.
REQ-043 vol=7 hp=0 dur=1 -> output 0 throughout; done at 10 cycles.
REQ-044 mute pulsed mid-note -> output 0 while high; done timing unchanged.
REQ-045 rst_n low mid-SFX_OVER_MUS -> outputs 0, active_src=00, no done pulses; a new mus_req after release is acked normally.
